// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : imm_encoder
//  Brief    : Pipelined immediate encoder (inverse of the immediate extender).
//             Picks zero-ext16 / sign-ext16 / sign-ext20, or splits a 32-bit
//             constant into an upper/lower pair of 16-bit beats.
//  Revision : 1.0  initial release
// ============================================================================
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      value_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [19:0]      imm_o,
  output logic [1:0]       sel_o,
  output logic             hi_o,
  output logic             last_o,
  output logic [CNT_W-1:0] split_cnt_o
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_LO    = 1'b1;

  localparam logic [1:0] SEL_Z16 = 2'b00;
  localparam logic [1:0] SEL_S16 = 2'b01;
  localparam logic [1:0] SEL_S20 = 2'b10;

  logic [0:0]       state_q;
  logic [0:0]       state_d;
  logic [15:0]      lo_q;
  logic [15:0]      lo_d;
  logic             valid_d;
  logic [19:0]      imm_d;
  logic [1:0]       sel_d;
  logic             hi_d;
  logic             last_d;
  logic [CNT_W-1:0] cnt_d;

  logic             accept;
  logic             is_split;
  logic [1:0]       cls_sel;
  logic [19:0]      cls_imm;

  // Cheapest encoding of the incoming constant; earlier rules take priority.
  always_comb begin
    is_split = 1'b0;
    cls_sel  = SEL_Z16;
    cls_imm  = {4'b0, value_i[15:0]};
    if (value_i[31:16] == 16'h0000) begin
      cls_sel = SEL_Z16;
    end else if (value_i[31:16] == {16{value_i[15]}}) begin
      cls_sel = SEL_S16;
    end else if (value_i[31:20] == {12{value_i[19]}}) begin
      cls_sel = SEL_S20;
      cls_imm = value_i[19:0];
    end else begin
      // First beat of a split carries the upper half, zero-extended.
      is_split = 1'b1;
      cls_sel  = SEL_Z16;
      cls_imm  = {4'b0, value_i[31:16]};
    end
  end

  // A new constant may enter only when no lower half is pending and the
  // output register is free or being drained this cycle.
  assign in_ready_o = (state_q == S_IDLE) && (!out_valid_o || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  // Register update: state, output beat, pending lower half and statistics.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      out_valid_o <= 1'b0;
      imm_o       <= 20'h0;
      sel_o       <= SEL_Z16;
      hi_o        <= 1'b0;
      last_o      <= 1'b0;
      lo_q        <= 16'h0;
      split_cnt_o <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_o <= valid_d;
      imm_o       <= imm_d;
      sel_o       <= sel_d;
      hi_o        <= hi_d;
      last_o      <= last_d;
      lo_q        <= lo_d;
      split_cnt_o <= cnt_d;
    end
  end

  // Next-state: enter S_LO on an accepted split, leave once the upper beat drains.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_split) state_d = S_LO;
      S_LO:    if (out_ready_i)        state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next output-register contents; everything holds unless a beat moves.
  always_comb begin
    valid_d = out_valid_o;
    imm_d   = imm_o;
    sel_d   = sel_o;
    hi_d    = hi_o;
    last_d  = last_o;
    lo_d    = lo_q;
    cnt_d   = split_cnt_o;
    if (state_q == S_LO) begin
      if (out_ready_i) begin
        valid_d = 1'b1;
        imm_d   = {4'b0, lo_q};
        sel_d   = SEL_Z16;
        hi_d    = 1'b0;
        last_d  = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b1;
      imm_d   = cls_imm;
      sel_d   = cls_sel;
      hi_d    = is_split;
      last_d  = !is_split;
      if (is_split) begin
        lo_d = value_i[15:0];
        if (split_cnt_o != {CNT_W{1'b1}}) begin
          cnt_d = split_cnt_o + 1'b1;
        end
      end
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_encoder
//  Brief    : Self-checking bench for imm_encoder against a queue-based
//             reference model of the encoding rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imm_encoder;

  typedef struct packed {
    logic [19:0] imm;
    logic [1:0]  sel;
    logic        hi;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] value;
  logic        out_ready;

  logic        in_ready,    u2_in_ready;
  logic        out_valid,   u2_valid;
  logic [19:0] imm,         u2_imm;
  logic [1:0]  sel,         u2_sel;
  logic        hi,          u2_hi;
  logic        last,        u2_last;
  logic [15:0] cnt1;
  logic [1:0]  cnt2;

  int    n_checks = 0;
  int    n_err    = 0;
  beat_t q[$];
  int    m_cnt1;
  int    m_cnt2;
  bit    last_acc;

  always #5 clk = ~clk;

  imm_encoder #(.CNT_W(16)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .value_i(value), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .imm_o(imm), .sel_o(sel), .hi_o(hi), .last_o(last), .split_cnt_o(cnt1)
  );

  imm_encoder #(.CNT_W(2)) u_dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(u2_in_ready),
    .value_i(value), .out_valid_o(u2_valid), .out_ready_i(out_ready),
    .imm_o(u2_imm), .sel_o(u2_sel), .hi_o(u2_hi), .last_o(u2_last), .split_cnt_o(cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Encoding rules written as numeric ranges on the constant.
  task automatic classify(input logic [31:0] v, output beat_t b0, output beat_t b1,
                          output bit split);
    int signed sv;
    sv    = int'(v);
    split = 1'b0;
    b1    = '0;
    b0.hi = 1'b0; b0.last = 1'b1;
    if (v < 32'd65536) begin
      b0.sel = 2'd0; b0.imm = 20'(v);
    end else if (sv >= -32768 && sv <= 32767) begin
      b0.sel = 2'd1; b0.imm = 20'(v % 65536);
    end else if (sv >= -524288 && sv <= 524287) begin
      b0.sel = 2'd2; b0.imm = 20'(v % 1048576);
    end else begin
      split   = 1'b1;
      b0.sel  = 2'd0; b0.imm = 20'(v / 65536); b0.hi = 1'b1; b0.last = 1'b0;
      b1.sel  = 2'd0; b1.imm = 20'(v % 65536); b1.hi = 1'b0; b1.last = 1'b1;
    end
  endtask

  // One clock: check ready mid-cycle, advance the model at the edge, check outputs after.
  task automatic tick();
    bit    rdy, acc, cons, split;
    beat_t b0, b1;
    @(negedge clk);
    rdy = (q.size() < 2) && (q.size() == 0 || out_ready);
    if (rst_n) begin
      check("in_ready", in_ready, rdy);
      check("u2_in_ready", u2_in_ready, rdy);
    end
    acc  = in_valid && rdy;
    cons = (q.size() > 0) && out_ready;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_cnt1 = 0; m_cnt2 = 0; last_acc = 1'b0;
    end else begin
      if (cons) void'(q.pop_front());
      last_acc = acc;
      if (acc) begin
        classify(value, b0, b1, split);
        q.push_back(b0);
        if (split) begin
          q.push_back(b1);
          if (m_cnt1 < 65535) m_cnt1++;
          if (m_cnt2 < 3)     m_cnt2++;
        end
      end
    end
    #1;
    check("out_valid", out_valid, q.size() > 0);
    check("u2_out_valid", u2_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("imm",  imm,  q[0].imm);
      check("sel",  sel,  q[0].sel);
      check("hi",   hi,   q[0].hi);
      check("last", last, q[0].last);
      check("u2_imm", u2_imm, q[0].imm);
      check("u2_sel", u2_sel, q[0].sel);
      check("u2_hi_last", {u2_hi, u2_last}, {q[0].hi, q[0].last});
    end
    check("split_cnt", cnt1, 32'(m_cnt1));
    check("u2_split_cnt", cnt2, 32'(m_cnt2));
  endtask

  // Present a constant and keep it up until accepted (bounded).
  task automatic push(input logic [31:0] v);
    in_valid = 1'b1;
    value    = v;
    last_acc = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (last_acc) break;
    end
    check("accept_timeout", last_acc, 1'b1);
  endtask

  function automatic logic [31:0] rand_value();
    int unsigned r;
    logic [31:0] v;
    r = $urandom_range(0, 4);
    case (r)
      0: v = $urandom % 65536;
      1: v = 32'(-32768 + int'($urandom % 65536));
      2: v = 32'(-524288 + int'($urandom % 1048576));
      3: v = $urandom;
      default: begin
        v = $urandom;
        v[31:16] = {16{v[15]}} ^ 16'(1 << $urandom_range(0, 15));
      end
    endcase
    return v;
  endfunction

  initial begin
    int exp_sat[5];
    exp_sat = '{1, 2, 3, 3, 3};
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    value     = 32'h0;
    out_ready = 1'b0;
    m_cnt1 = 0; m_cnt2 = 0; last_acc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_imm", imm, 20'h0);
    check("rst_sel", sel, 2'b00);
    check("rst_hi_last", {hi, last}, 2'b00);
    check("rst_cnt", cnt1, 16'h0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b1);

    // Back-to-back single-beat encodings.
    out_ready = 1'b1;
    push(32'h0000_8000);
    push(32'hFFFF_8000);
    push(32'h0007_FFFF);
    push(32'hFFF8_0000);
    in_valid = 1'b0;
    repeat (2) tick();

    // Simple split.
    push(32'h1234_5678);
    in_valid = 1'b0;
    repeat (3) tick();

    // Split under backpressure.
    out_ready = 1'b0;
    push(32'hDEAD_BEEF);
    in_valid = 1'b0;
    repeat (5) tick();
    out_ready = 1'b1;
    repeat (3) tick();

    // Priority edge cases.
    push(32'h0000_0000);
    push(32'hFFFF_FFFF);
    push(32'h0001_0000);
    push(32'h8000_0000);
    in_valid = 1'b0;
    repeat (3) tick();

    // Reset while the lower half is pending.
    out_ready = 1'b0;
    push(32'hCAFE_BABE);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("midsplit_rst_valid", out_valid, 1'b0);
    check("midsplit_rst_cnt", cnt1, 16'h0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();
    push(32'h0000_0005);
    in_valid = 1'b0;
    repeat (2) tick();

    // Counter saturation on the narrow instance.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(32'h4000_0000 + 32'(i));
      check("sat_cnt2", cnt2, 32'(exp_sat[i]));
    end
    in_valid = 1'b0;
    repeat (3) tick();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      value     = rand_value();
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imm_encoder.md
# imm_encoder

Pipelined immediate encoder for the processor toolchain/loader path. It is the inverse of the core's immediate extender. It accepts 32-bit constants over a valid/ready stream and picks the cheapest immediate encoding the extender can reconstruct: zero-extend 16, sign-extend 16, or sign-extend 20. Constants that fit none of these are split into an upper/lower pair of 16-bit beats (upper shifted by 16, lower zero-extended and OR-ed in). It sits between the constant source (loader/assembler FSM) and the instruction word builder.

## Interface

Parameters:
- CNT_W, 16, width of the saturating split-statistics counter

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_n_i  input  1  synchronous reset, active-low
- in_valid_i  input  1  constant available
- in_ready_o  output  1  constant accepted this cycle when high with in_valid_i
- value_i  input  32  constant to encode
- out_valid_o  output  1  encoded beat available
- out_ready_i  input  1  consumer takes beat when high with out_valid_o
- imm_o  output  20  immediate field
- sel_o  output  2  extender selector: 00 zero-ext16, 01 sign-ext16, 10 sign-ext20
- hi_o  output  1  beat is the upper half of a split (consumer shifts left 16)
- last_o  output  1  final beat for this constant
- split_cnt_o  output  CNT_W  number of constants that required splitting, saturating

## Operation

- Classification of value_i, first match wins:
  - value[31:16]==0: single beat, sel=00, imm={4'b0,value[15:0]}.
  - value[31:16]=={16{value[15]}}: single beat, sel=01, imm={4'b0,value[15:0]}.
  - value[31:20]=={12{value[19]}}: single beat, sel=10, imm=value[19:0].
  - Otherwise split: beat 1 sel=00, imm={4'b0,value[31:16]}, hi=1, last=0. Beat 2 sel=00, imm={4'b0,value[15:0]}, hi=0, last=1.
- Single beats always drive hi=0 and last=1.
- FSM states:
  - S_IDLE: no lower half pending.
  - S_LO: upper-half beat is in the output register; the lower 16 bits are held in lo_q.
- in_ready_o = (state==S_IDLE) && (!out_valid_o || out_ready_i). This is combinational from out_ready_i.
- Accept (in_valid_i && in_ready_o): load the output register with the first beat and set out_valid_o=1. On a split, go to S_LO, capture lo_q, and increment split_cnt_o unless it is all-ones.
- S_LO with out_ready_i=1: load the lower beat and return to S_IDLE. out_valid_o stays 1.
- S_LO with out_ready_i=0: hold everything.
- S_IDLE, beat consumed, no accept: out_valid_o=0.
- S_IDLE, beat consumed and new accept in the same cycle: the register reloads, out_valid_o stays 1, giving back-to-back throughput.
- Output register contents stay stable while out_valid_o=1 and out_ready_i=0.

## Timing

- Reset (rst_n_i=0 sampled at an edge) sets:
  - state=S_IDLE, out_valid_o=0, imm_o=0, sel_o=00, hi_o=0, last_o=0, lo_q=0, split_cnt_o=0.
  - in_ready_o=1 in the first cycle after reset.
- Reset mid-split discards the pending lower half. No beat is emitted for it.
- Latency: a beat appears on out_valid_o one cycle after the accepting edge.
- Throughput:
  - 1 constant/cycle for single-beat encodings when out_ready_i is held high.
  - A split occupies 2 output cycles, and in_ready_o=0 during S_LO.
- split_cnt_o saturates at 2^CNT_W-1. It never wraps.
- in_valid_i may drop without acceptance. The block samples value_i only at accept.

## Test plan

- Reset, then push 0x00008000, 0xFFFF8000, 0x0007FFFF, 0xFFF80000 back-to-back with out_ready_i=1. Required: four beats on consecutive cycles with (sel, imm) = (00,0x08000), (01,0x08000), (10,0x7FFFF), (10,0x80000), all with last=1, hi=0. in_ready_o stays 1 throughout.
- Push 0x12345678. Required:
  - beat (00,0x01234,hi=1,last=0), then (00,0x05678,hi=0,last=1);
  - in_ready_o=0 for the cycle between the two beats;
  - split_cnt_o becomes 1.
- Backpressure: hold out_ready_i=0 for 5 cycles after accepting 0xDEADBEEF. Required: beat (00,0x0DEAD,hi=1) stable, in_ready_o=0, and the lower beat 0x0BEEF follows one cycle after out_ready_i rises.
- Priority edge cases:
  - 0x00000000 gives sel=00;
  - 0xFFFFFFFF gives sel=01, imm=0x0FFFF;
  - 0x00010000 gives sel=10, imm=0x10000;
  - 0x80000000 gives split hi=0x08000, lo=0x00000.
- Assert rst_n_i low in S_LO after the upper beat of 0xCAFEBABE is shown. Required: the next cycle has out_valid_o=0 and split_cnt_o=0, no 0x0BABE beat ever appears, and the next input encodes normally.
- With CNT_W=2, push 5 splitting constants. Required: split_cnt_o reads 1, 2, 3, 3, 3.
